// File: rtl/lvds_8b10b_frame_send.sv
// Framed 8b10b serializer: per-frame comma header, NUM_BYTES data symbols, idle fill,
// one serial bit per clock, LSB of each 10-bit code first.
module lvds_8b10b_frame_send #(
  parameter int          NUM_BYTES        = 2,
  parameter logic [8:0]  COMMA_CODE       = 9'h13C,
  parameter logic [8:0]  IDLE_CODE        = 9'h1BC,
  parameter int          FRAME_COUNT_BITS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [8*NUM_BYTES-1:0]      data_i,
  input  logic [NUM_BYTES-1:0]        k_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic                        enable_i,
  output logic                        serial_o,
  output logic                        idle_o,
  output logic [FRAME_COUNT_BITS-1:0] frame_count_o
);

  localparam int SW = (NUM_BYTES < 2) ? 1 : $clog2(NUM_BYTES + 1);

  // Returns {dispout, code}; code[0] is 'a' (first on the line), code[9] is 'j'.
  function automatic logic [10:0] encode8b10b(input logic [8:0] din, input logic disp_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       k28, n6, n4, rd_mid, comp4;
    logic [5:0] s6;
    logic [3:0] s4;
    logic [9:0] code;
    x   = din[4:0];
    y   = din[7:5];
    k28 = din[8] && (x == 5'd28);
    s6  = 6'b100111;
    case (x)
      5'd0:  s6 = 6'b100111;  5'd1:  s6 = 6'b011101;  5'd2:  s6 = 6'b101101;
      5'd3:  s6 = 6'b110001;  5'd4:  s6 = 6'b110101;  5'd5:  s6 = 6'b101001;
      5'd6:  s6 = 6'b011001;  5'd7:  s6 = 6'b111000;  5'd8:  s6 = 6'b111001;
      5'd9:  s6 = 6'b100101;  5'd10: s6 = 6'b010101;  5'd11: s6 = 6'b110100;
      5'd12: s6 = 6'b001101;  5'd13: s6 = 6'b101100;  5'd14: s6 = 6'b011100;
      5'd15: s6 = 6'b010111;  5'd16: s6 = 6'b011011;  5'd17: s6 = 6'b100011;
      5'd18: s6 = 6'b010011;  5'd19: s6 = 6'b110010;  5'd20: s6 = 6'b001011;
      5'd21: s6 = 6'b101010;  5'd22: s6 = 6'b011010;  5'd23: s6 = 6'b111010;
      5'd24: s6 = 6'b110011;  5'd25: s6 = 6'b100110;  5'd26: s6 = 6'b010110;
      5'd27: s6 = 6'b110110;  5'd28: s6 = 6'b001110;  5'd29: s6 = 6'b101110;
      5'd30: s6 = 6'b011110;  5'd31: s6 = 6'b101011;
      default: s6 = 6'b100111;
    endcase
    if (k28) s6 = 6'b001111;
    n6 = ($countones(s6) == 3);
    // D.07 is balanced but still has an RD+ alternate form
    if (disp_in && (!n6 || s6 == 6'b111000)) s6 = ~s6;
    rd_mid = n6 ? disp_in : ~disp_in;
    case (y)
      3'd0: s4 = 4'b1011;  3'd1: s4 = 4'b1001;  3'd2: s4 = 4'b0101;  3'd3: s4 = 4'b1100;
      3'd4: s4 = 4'b1101;  3'd5: s4 = 4'b1010;  3'd6: s4 = 4'b0110;
      default: s4 = (din[8] || (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                     (rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14))) ? 4'b0111 : 4'b1110;
    endcase
    n4 = ($countones(s4) == 2);
    // K28 balanced 4b codes alternate against the mid-symbol disparity
    if (k28 && n4 && s4 != 4'b1100) comp4 = !rd_mid;
    else                            comp4 = rd_mid && (!n4 || s4 == 4'b1100);
    if (comp4) s4 = ~s4;
    for (int i = 0; i < 6; i++) code[i]   = s6[5-i];
    for (int i = 0; i < 4; i++) code[6+i] = s4[3-i];
    return {(n4 ? rd_mid : ~rd_mid), code};
  endfunction

  logic [3:0]                  bit_q, bit_d;
  logic [SW-1:0]               slot_q, slot_d;
  logic                        acc_q, acc_d;
  logic                        ready_q, ready_d;
  logic [8*NUM_BYTES-1:0]      data_q, data_d;
  logic [NUM_BYTES-1:0]        k_q, k_d;
  logic [8:0]                  code_q, code_d;
  logic                        code_idle_q, code_idle_d;
  logic [8:0]                  enc_in_q, enc_in_d;
  logic                        enc_rd_q, enc_rd_d;
  logic                        idle_q, idle_d;
  logic                        rd_q, rd_d;
  logic [9:0]                  shreg_q, shreg_d;
  logic                        serial_q, serial_d;
  logic [FRAME_COUNT_BITS-1:0] cnt_q, cnt_d;
  logic [10:0]                 enc_out;
  logic [8:0]                  data_code;

  assign enc_out = encode8b10b(enc_in_q, enc_rd_q);

  always_comb begin
    data_code = IDLE_CODE;
    for (int n = 0; n < NUM_BYTES; n++)
      if (slot_q == SW'(n + 1)) data_code = {k_q[n], data_q[8*n +: 8]};
  end

  always_comb begin
    bit_d       = (bit_q == 4'd9) ? 4'd0 : bit_q + 4'd1;
    slot_d      = slot_q;
    acc_d       = acc_q;
    ready_d     = enable_i && (slot_q == '0) && (bit_q == 4'd2);
    data_d      = data_q;
    k_d         = k_q;
    code_d      = code_q;
    code_idle_d = code_idle_q;
    enc_in_d    = enc_in_q;
    enc_rd_d    = enc_rd_q;
    idle_d      = idle_q;
    rd_d        = rd_q;
    shreg_d     = shreg_q >> 1;
    serial_d    = shreg_q[0];
    cnt_d       = cnt_q;

    // ready_q is only ever high at bit 3 of a slot-0 period
    if (ready_q && valid_i) begin
      data_d = data_i;
      k_d    = k_i;
      acc_d  = 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end

    // Selection and encoder input are pipelined one period apart so the
    // data registers can be reloaded by a back-to-back frame safely.
    if (bit_q == 4'd4) begin
      enc_in_d = code_q;
      enc_rd_d = rd_q;
      idle_d   = code_idle_q;
      if (slot_q == '0) begin
        code_d      = acc_q ? COMMA_CODE : IDLE_CODE;
        code_idle_d = !acc_q;
      end else begin
        code_d      = data_code;
        code_idle_d = 1'b0;
      end
    end

    if (bit_q == 4'd9) begin
      shreg_d = enc_out[9:0];
      rd_d    = enc_out[10];
      acc_d   = 1'b0;
      if (slot_q == '0)                   slot_d = acc_q ? SW'(1) : '0;
      else if (slot_q == SW'(NUM_BYTES))  slot_d = '0;
      else                                slot_d = slot_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_q       <= '0;
      slot_q      <= '0;
      acc_q       <= 1'b0;
      ready_q     <= 1'b0;
      data_q      <= '0;
      k_q         <= '0;
      code_q      <= IDLE_CODE;
      code_idle_q <= 1'b1;
      enc_in_q    <= IDLE_CODE;
      enc_rd_q    <= 1'b0;
      idle_q      <= 1'b1;
      rd_q        <= 1'b0;
      shreg_q     <= 10'b1010101010;
      serial_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      bit_q       <= bit_d;
      slot_q      <= slot_d;
      acc_q       <= acc_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
      k_q         <= k_d;
      code_q      <= code_d;
      code_idle_q <= code_idle_d;
      enc_in_q    <= enc_in_d;
      enc_rd_q    <= enc_rd_d;
      idle_q      <= idle_d;
      rd_q        <= rd_d;
      shreg_q     <= shreg_d;
      serial_q    <= serial_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ready_o       = ready_q;
  assign serial_o      = serial_q;
  assign idle_o        = idle_q;
  assign frame_count_o = cnt_q;

endmodule
